// File: rtl/rtc_display_scan.sv
// Time-multiplexed driver for a shared 6-digit 7-segment display.
// Snapshots the clock digits once per frame and blanks the anodes at the start of every slot.
module rtc_display_scan #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter bit AN_ACTIVE_LOW = 1'b1,
    parameter bit SEG_INVERT    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] hrm,
    input  logic [6:0] hrl,
    input  logic [6:0] min_m,
    input  logic [6:0] min_l,
    input  logic [6:0] sec_m,
    input  logic [6:0] sec_l,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [5:0]    AN_OFF     = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic [6:0]    SEG_OFF    = SEG_INVERT ? 7'h00 : 7'h7F;
    localparam logic [6:0]    BLANK_CODE = 7'h7F;

    // Slot order matches the anode numbering: slot k drives an[k].
    typedef enum logic [2:0] {
        D_SEC_L = 3'd0,
        D_SEC_M = 3'd1,
        D_MIN_L = 3'd2,
        D_MIN_M = 3'd3,
        D_HR_L  = 3'd4,
        D_HR_M  = 3'd5
    } digit_e;

    typedef logic [5:0][6:0] snap_t;

    logic [CW-1:0] cnt_q, cnt_d;
    digit_e        idx_q, idx_d;
    snap_t         snap_q, snap_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_start_q, frame_start_d;

    logic       frame_tick;
    logic       blank;
    logic [5:0] an_sel;
    logic [6:0] code;

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latches).
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        an_d          = AN_OFF;
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;

        frame_tick = (idx_q == D_SEC_L) && (cnt_q == '0);
        blank      = (cnt_q < BLANK_END);
        an_sel     = 6'b000001 << idx_q;
        code       = snap_q[idx_q];

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == D_HR_M) ? D_SEC_L : digit_e'(idx_q + 3'd1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // The whole frame shows one coherent time value; inputs are ignored elsewhere.
        if (frame_tick) begin
            snap_d = {hrm, hrl, min_m, min_l, sec_m, sec_l};
        end

        if (!blank) begin
            an_d  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
            seg_d = SEG_INVERT ? ~code : code;
            if (colon_en && (idx_q == D_MIN_L || idx_q == D_HR_L)) begin
                dp_d = 1'b0;
            end
        end

        frame_start_d = frame_tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            idx_q         <= D_SEC_L;
            // NOTE: the snapshot registers are reset so a blank display is shown before the first capture.
            snap_q        <= {6{BLANK_CODE}};
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rtc_display_scan.sv
// Directed bench for rtc_display_scan: reset, scan order, tearing, colon, exclusivity,
// mid-frame reset and output polarity, all against hand-derived expectations.
module tb_rtc_display_scan;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic [6:0] hrm, hrl, min_m, min_l, sec_m, sec_l;
    logic       colon_en;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [5:0] an_a, an_b;
    logic       fs_a, fs_b;

    int total = 0;
    int bad   = 0;

    logic [6:0] mdl [6];
    logic       colon_exp;

    rtc_display_scan #(
        .SCAN_DIV(4), .BLANK_CYCLES(1), .AN_ACTIVE_LOW(1'b1), .SEG_INVERT(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .min_m(min_m), .min_l(min_l),
        .sec_m(sec_m), .sec_l(sec_l), .colon_en(colon_en),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a)
    );

    rtc_display_scan #(
        .SCAN_DIV(4), .BLANK_CYCLES(1), .AN_ACTIVE_LOW(1'b0), .SEG_INVERT(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .min_m(min_m), .min_l(min_l),
        .sec_m(sec_m), .sec_l(sec_l), .colon_en(colon_en),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b)
    );

    initial begin
        forever #5 if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int s, k, ph;
        logic lit;
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        logic exp_dp;

        // Reset with arbitrary inputs, no clock running.
        rst = 1'b1;
        {hrm, hrl, min_m, min_l, sec_m, sec_l} = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
        colon_en = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_an_a",  an_a,  6'h3F);
        check("rst_seg_a", seg_a, 7'h7F);
        check("rst_dp_a",  dp_a,  1'b1);
        check("rst_fs_a",  fs_a,  1'b0);
        check("rst_an_b",  an_b,  6'h00);
        check("rst_seg_b", seg_b, 7'h00);
        check("rst_dp_b",  dp_b,  1'b1);

        // Clock runs while reset is held: outputs must stay inactive.
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rsthold_an",  an_a,  6'h3F);
        check("rsthold_seg", seg_a, 7'h7F);
        check("rsthold_fs",  fs_a,  1'b0);

        sec_l = 7'h40; sec_m = 7'h79; min_l = 7'h24;
        min_m = 7'h30; hrl   = 7'h19; hrm   = 7'h12;
        colon_en  = 1'b0;
        colon_exp = 1'b0;
        for (int i = 0; i < 6; i++) mdl[i] = 7'h7F;
        @(negedge clk);
        rst = 1'b1;

        // Frames 1-2 without colon, tearing change in frame 2, colon enabled for frame 3.
        for (int c = 1; c <= 87; c++) begin
            @(posedge clk);
            #2;
            s  = (c - 1) % 24;
            k  = s / 4;
            ph = s % 4;
            if (s == 0) begin
                mdl[0] = sec_l; mdl[1] = sec_m; mdl[2] = min_l;
                mdl[3] = min_m; mdl[4] = hrl;   mdl[5] = hrm;
            end
            lit     = (ph != 0);
            exp_an  = lit ? ~(6'b000001 << k) : 6'h3F;
            exp_seg = lit ? mdl[k] : 7'h7F;
            exp_dp  = (colon_exp && lit && (k == 2 || k == 4)) ? 1'b0 : 1'b1;
            check($sformatf("an_c%0d", c),   an_a,  exp_an);
            check($sformatf("seg_c%0d", c),  seg_a, exp_seg);
            check($sformatf("dp_c%0d", c),   dp_a,  exp_dp);
            check($sformatf("fs_c%0d", c),   fs_a,  (s == 0));
            check($sformatf("excl_c%0d", c), ($countones(~an_a) <= 1), 1'b1);
            if (c == 2) begin
                check("pol_an_b",  an_b,  6'h01);
                check("pol_seg_b", seg_b, 7'h3F);
            end
            if (c == 37) sec_l = 7'h79;
            if (c == 48) begin
                colon_en  = 1'b1;
                colon_exp = 1'b1;
            end
        end

        // Mid-frame reset during slot 3: outputs drop without a clock edge.
        rst = 1'b0;
        #1;
        check("mid_rst_an",  an_a,  6'h3F);
        check("mid_rst_seg", seg_a, 7'h7F);
        check("mid_rst_dp",  dp_a,  1'b1);
        check("mid_rst_an_b", an_b, 6'h00);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rel_fs",  fs_a, 1'b1);
        check("rel_an",  an_a, 6'h3F);
        @(posedge clk);
        #2;
        check("rel_fs_low", fs_a,  1'b0);
        check("rel_an0",    an_a,  6'h3E);
        check("rel_seg0",   seg_a, 7'h79);
        check("rel_dp0",    dp_a,  1'b1);
        check("rel_an_b",   an_b,  6'h01);
        check("rel_seg_b",  seg_b, 7'h06);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
